hdb3_encoding: RTL
==================

Name: hdb3_encoding

Overview:
- HDB3 line encoder: converts a serial binary stream into 3-bit HDB3 symbol codes. Its output pair (encoding_data, encoding_instruction) drives the codebase's HDB3 decoder directly.
- A 4-bit look-ahead pipeline detects runs of four zeros and substitutes 000V or B00V, chosen by pulse parity since the last V.
- Symbol code: bit2 = polarity (0 = +, 1 = -); bits[1:0] = 00 zero, 01 mark, 10 violation V, 11 balancing pulse B.

Parameters:
- INIT_NEG, 1, initial value of the last-pulse polarity register (1 = negative, so the first pulse after reset is +).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-low.
- data_in  input  1  source data bit.
- data_valid  input  1  data_in is valid this cycle; each valid cycle accepts one bit.
- flush  input  1  end-of-stream drain request; used only when data_valid = 0.
- encoding_data  output  3  HDB3 symbol code (format above).
- encoding_instruction  output  1  encoding_data is valid this cycle.

Behaviour:
- Reset (rst low at posedge): encoding_data = 3'b000, encoding_instruction = 0, all stage valids cleared, last_pol = INIT_NEG, parity = even. Reset mid-stream discards all buffered bits.
- Pipeline: stages s0 (newest) .. s3 (oldest). Each stage holds a data bit, a valid flag and a tag (none / V / B).
- Advance condition: data_valid = 1, or (flush = 1 and data_valid = 0).
- On advance:
  - s3 is emitted if valid.
  - s2..s0 shift up one stage.
  - s0 loads data_in with valid = data_valid (bubble when flushing).
- No advance: pipeline holds. Gaps in data_valid do not break a zero run, because runs are counted in bits, not cycles.
- Outputs are registered. In the cycle after an advance with s3 valid: encoding_instruction = 1 and encoding_data = emitted symbol. In every other cycle: encoding_instruction = 0 and encoding_data = 000.
- Latency (continuous stream): the symbol for bit k appears one clock after bit k+4 is accepted.
- Emission rules:
  - Untagged 0 -> 000.
  - Untagged 1 (mark) -> polarity opposite to last_pol; code 001 or 101. Update last_pol; toggle parity.
  - B tag -> opposite polarity; code 011 or 111. Update last_pol; toggle parity.
  - V tag -> same polarity as last_pol; code 010 or 110. last_pol unchanged; parity forced to even.
- Substitution check, evaluated on every advance with data_valid = 1:
  - Condition: incoming bit = 0 and s2, s1, s0 all valid, untagged zeros.
  - Action: the incoming bit is loaded into s0 with tag V.
  - If parity_next is even, the bit moving into s3 (old s2) is also tagged B. If odd, no B tag (000V).
  - parity_next = parity after applying this same cycle's emission, including reset-to-even if the emitted symbol is V.
- Flush: bubbles never trigger substitution. Trailing runs of fewer than four zeros are emitted as plain 000. Flush with the pipeline empty has no effect.
- data_valid and flush both high: treated as a normal data advance; flush is ignored that cycle.
- Never emitted: 100 (negative zero).

Test Plan:
- Reset, then 1,0,0,0,0,1, then flush until empty -> 001,000,000,000,010,101 (odd parity gives 000V).
- Reset, then eight 0s, then flush -> 011,000,000,010,111,000,000,110 (B00V twice, polarity alternating).
- Reset, then 1,1,0,0,0,0, then flush -> 001,101,011,000,000,010 (even parity gives B00V).
- Reset, then 0,0,0, then flush -> 000,000,000; no V/B tag; encoding_instruction = 1 for exactly 3 cycles.
- Reset, then 0,0 with data_valid idle for 5 cycles, then 0,0, then flush -> 011,000,000,010; no output during the idle gap.
- Mid-stream rst low for 1 cycle -> next cycle output 000 with encoding_instruction = 0; a following 1 emits 001 (INIT_NEG restored).

Source files
------------

// File: rtl/hdb3_encoding_if.sv
// HDB3 encoder stream interface: serial source bits in, 3-bit symbol codes out.
interface hdb3_encoding_if;
    logic       data_in;
    logic       data_valid;
    logic       flush;
    logic [2:0] encoding_data;
    logic       encoding_instruction;

    // Source side drives bits and drain requests, sees symbols.
    modport master (
        output data_in, data_valid, flush,
        input  encoding_data, encoding_instruction
    );

    // Encoder side.
    modport slave (
        input  data_in, data_valid, flush,
        output encoding_data, encoding_instruction
    );
endinterface

// File: rtl/hdb3_encoding.sv
// HDB3 line encoder. A four-stage look-ahead pipeline spots runs of four
// zeros and rewrites them as 000V or B00V depending on pulse parity since the
// last violation. Symbol code: bit2 = polarity (1 = negative), bits[1:0] =
// 00 zero, 01 mark, 10 violation, 11 balancing pulse.
module hdb3_encoding #(
    parameter bit INIT_NEG = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    hdb3_encoding_if.slave      bus
);

    localparam logic [1:0] TAG_NONE = 2'b00;
    localparam logic [1:0] TAG_V    = 2'b01;
    localparam logic [1:0] TAG_B    = 2'b10;

    // Stage 0 is the newest bit, stage 3 the oldest (next to be emitted).
    logic [3:0]      dat_q, dat_d;
    logic [3:0]      vld_q, vld_d;
    logic [3:0][1:0] tag_q, tag_d;
    logic            last_pol_q, last_pol_d;   // polarity of last pulse, 1 = negative
    logic            parity_q, parity_d;       // 1 = odd pulse count since last V
    logic [2:0]      enc_data_q, enc_data_d;
    logic            enc_instr_q, enc_instr_d;

    logic advance;
    logic zero_run;

    assign advance = bus.data_valid | bus.flush;

    // Three buffered untagged zeros plus an incoming zero make a run of four.
    assign zero_run = bus.data_valid && !bus.data_in
                   && (&vld_q[2:0]) && !(|dat_q[2:0])
                   && (tag_q[2] == TAG_NONE) && (tag_q[1] == TAG_NONE)
                   && (tag_q[0] == TAG_NONE);

    // Next-state: emission from stage 3, shift, and zero-run substitution.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        dat_d       = dat_q;
        vld_d       = vld_q;
        tag_d       = tag_q;
        last_pol_d  = last_pol_q;
        parity_d    = parity_q;
        enc_data_d  = 3'b000;
        enc_instr_d = 1'b0;

        if (advance) begin
            if (vld_q[3]) begin
                enc_instr_d = 1'b1;
                case (tag_q[3])
                    TAG_V: begin
                        enc_data_d = {last_pol_q, 2'b10};
                        parity_d   = 1'b0;
                    end
                    TAG_B: begin
                        enc_data_d = {~last_pol_q, 2'b11};
                        last_pol_d = ~last_pol_q;
                        parity_d   = ~parity_q;
                    end
                    default: begin
                        if (dat_q[3]) begin
                            enc_data_d = {~last_pol_q, 2'b01};
                            last_pol_d = ~last_pol_q;
                            parity_d   = ~parity_q;
                        end
                    end
                endcase
            end

            // Flush bubbles enter with valid low and a clean zero data bit.
            dat_d = {dat_q[2:0], bus.data_in & bus.data_valid};
            vld_d = {vld_q[2:0], bus.data_valid};
            tag_d = {tag_q[2:0], TAG_NONE};

            // Parity here already reflects this cycle's emission.
            if (zero_run) begin
                tag_d[0] = TAG_V;
                if (!parity_d) begin
                    tag_d[3] = TAG_B;
                end
            end
        end
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            dat_q       <= '0;
            vld_q       <= '0;
            tag_q       <= '0;
            last_pol_q  <= INIT_NEG;
            parity_q    <= 1'b0;
            enc_data_q  <= 3'b000;
            enc_instr_q <= 1'b0;
        end else begin
            dat_q       <= dat_d;
            vld_q       <= vld_d;
            tag_q       <= tag_d;
            last_pol_q  <= last_pol_d;
            parity_q    <= parity_d;
            enc_data_q  <= enc_data_d;
            enc_instr_q <= enc_instr_d;
        end
    end

    assign bus.encoding_data        = enc_data_q;
    assign bus.encoding_instruction = enc_instr_q;

endmodule
